// File: rtl/gate_pkg.sv
// Shared definitions for 2-input gate stimulus/check blocks: function codes,
// sequencer states and the reference truth table.
package gate_pkg;

  localparam logic [2:0] GF_AND  = 3'b000;
  localparam logic [2:0] GF_OR   = 3'b001;
  localparam logic [2:0] GF_NAND = 3'b010;
  localparam logic [2:0] GF_NOR  = 3'b011;
  localparam logic [2:0] GF_XOR  = 3'b100;
  localparam logic [2:0] GF_XNOR = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDone
  } state_e;

  function automatic logic func_valid(logic [2:0] func);
    return func <= GF_XNOR;
  endfunction

  // Invalid codes never reach evaluation; they fall back to 0.
  function automatic logic gate_eval(logic [2:0] func, logic a, logic b);
    logic y;
    unique case (func)
      GF_AND:  y = a & b;
      GF_OR:   y = a | b;
      GF_NAND: y = ~(a & b);
      GF_NOR:  y = ~(a | b);
      GF_XOR:  y = a ^ b;
      GF_XNOR: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_stim_check_hold_timer.sv
// Per-vector hold counter: load sets the count to 1, clear to 0, en increments;
// hit flags count == hold.
module hold_timer #(
  parameter int unsigned HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              en,
  input  logic [HOLD_W-1:0] hold,
  output logic              hit
);

  logic [HOLD_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= HOLD_W'(1);
    end else if (en) begin
      count_q <= count_q + HOLD_W'(1);
    end
  end

  assign hit = (count_q == hold);

endmodule

// File: rtl/gate_stim_check.sv
// Stimulus sequencer for a 2-input gate: walks {a,b} through 00..11, holds each
// vector for the latched hold time and checks c against the expected function.
module gate_stim_check
  import gate_pkg::*;
#(
  parameter int unsigned HOLD_W = 8,
  parameter int unsigned ERR_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        func,
  input  logic [HOLD_W-1:0] hold,
  output logic              a,
  output logic              b,
  input  logic              c,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [3:0]        fail_vec
);

  localparam logic [ERR_W-1:0] ErrMax = '1;

  state_e            state_q, state_d;
  logic [2:0]        func_q, func_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [3:0]        fail_q, fail_d;
  logic              timer_load, timer_clear, timer_en, timer_hit;

  hold_timer #(
    .HOLD_W(HOLD_W)
  ) u_hold_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .clear(timer_clear),
    .en   (timer_en),
    .hold (hold_q),
    .hit  (timer_hit)
  );

  always_comb begin
    state_d     = state_q;
    func_d      = func_q;
    hold_d      = hold_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_d      = fail_q;
    timer_load  = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && func_valid(func)) begin
          func_d     = func;
          hold_d     = (hold == '0) ? HOLD_W'(1) : hold;
          err_d      = '0;
          fail_d     = '0;
          pass_d     = 1'b0;
          vec_d      = 2'd0;
          busy_d     = 1'b1;
          timer_load = 1'b1;
          state_d    = StDrive;
        end
      end
      StDrive: begin
        if (timer_hit) begin
          if (c != gate_eval(func_q, vec_q[1], vec_q[0])) begin
            if (err_q != ErrMax) begin
              err_d = err_q + ERR_W'(1);
            end
            fail_d[vec_q] = 1'b1;
          end
          if (vec_q != 2'd3) begin
            vec_d      = vec_q + 2'd1;
            timer_load = 1'b1;
          end else begin
            // Result is fixed on entry to DONE, including the final compare.
            pass_d      = (err_d == '0);
            busy_d      = 1'b0;
            done_d      = 1'b1;
            timer_clear = 1'b1;
            state_d     = StDone;
          end
        end else begin
          timer_en = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      func_q  <= GF_AND;
      hold_q  <= HOLD_W'(1);
      vec_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a        = vec_q[1];
  assign b        = vec_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_stim_check.sv
// Directed bench for gate_stim_check: table of full runs against a modelled
// cell, plus sequences for invalid start, mid-run start, saturation and reset.
module tb_gate_stim_check;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] func = 3'b000;
  logic [7:0] hold = 8'd0;
  logic       a, b, c, busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;

  logic       start1 = 1'b0;
  logic [2:0] func1 = 3'b000;
  logic [7:0] hold1 = 8'd0;
  logic       a1, b1, busy1, done1, pass1;
  logic       c1;
  logic [0:0] err_cnt1;
  logic [3:0] fail_vec1;

  int n_chk = 0;
  int n_fail = 0;
  int cell_mode = 0;  // 0 NAND, 1 const 1, 2 const 0, 3 XOR

  always #5 clk = ~clk;

  always_comb begin
    c = 1'b0;
    case (cell_mode)
      0: c = ~(a & b);
      1: c = 1'b1;
      2: c = 1'b0;
      3: c = a ^ b;
      default: c = 1'b0;
    endcase
  end

  assign c1 = 1'b0;

  gate_stim_check #(.HOLD_W(8), .ERR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func), .hold(hold),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  gate_stim_check #(.HOLD_W(8), .ERR_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .func(func1), .hold(hold1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err_cnt1), .fail_vec(fail_vec1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full run; poke > 0 re-pulses start during that cycle of the run.
  task automatic run_check(input string name, input logic [2:0] f, input logic [7:0] h,
                           input int mode, input int poke, input logic [2:0] exp_err,
                           input logic [3:0] exp_fail, input logic exp_pass);
    int heff, busy_n, done_n, done_at, ab_bad;
    heff = (h == 8'd0) ? 1 : int'(h);
    busy_n = 0; done_n = 0; done_at = 0; ab_bad = 0;
    cell_mode = mode;
    @(negedge clk);
    start = 1'b1; func = f; hold = h;
    @(negedge clk);
    start = 1'b0; func = 3'b111; hold = 8'd9;  // must be ignored mid-run
    for (int j = 1; j <= 4 * heff + 6; j++) begin
      if (j > 1) @(negedge clk);
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = j; end
      if (j <= 4 * heff && {a, b} != 2'((j - 1) / heff)) ab_bad++;
      start = (j == poke);
    end
    start = 1'b0;
    chk({name, " busy_cycles"}, busy_n, 4 * heff);
    chk({name, " done_count"}, done_n, 1);
    chk({name, " done_cycle"}, done_at, 4 * heff + 1);
    chk({name, " ab_sequence"}, ab_bad, 0);
    chk({name, " err_cnt"}, err_cnt, exp_err);
    chk({name, " fail_vec"}, fail_vec, exp_fail);
    chk({name, " pass"}, pass, exp_pass);
    chk({name, " ab_final"}, {a, b}, 2'b11);
  endtask

  typedef struct {
    string      name;
    logic [2:0] f;
    logic [7:0] h;
    int         mode;
    logic [2:0] exp_err;
    logic [3:0] exp_fail;
    logic       exp_pass;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int done_n, first_at, second_at, busy_n;

    tbl[0] = '{"nand_ok",     3'b010, 8'd5, 0, 3'd0, 4'b0000, 1'b1};
    tbl[1] = '{"nand_as_and", 3'b000, 8'd5, 0, 3'd4, 4'b1111, 1'b0};
    tbl[2] = '{"one_as_nor",  3'b011, 8'd0, 1, 3'd3, 4'b1110, 1'b0};
    tbl[3] = '{"xor_ok",      3'b100, 8'd2, 3, 3'd0, 4'b0000, 1'b1};
    tbl[4] = '{"nand_as_xnor",3'b101, 8'd1, 0, 3'd3, 4'b1110, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_ab", {a, b}, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_pass", pass, 1'b0);
    chk("reset_err", err_cnt, 3'd0);
    chk("reset_fail", fail_vec, 4'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_check(tbl[i].name, tbl[i].f, tbl[i].h, tbl[i].mode, 0,
                tbl[i].exp_err, tbl[i].exp_fail, tbl[i].exp_pass);
    end

    // Invalid function code: nothing starts, results of the last run hold.
    @(negedge clk);
    start = 1'b1; func = 3'b110; hold = 8'd2;
    busy_n = 0; done_n = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) done_n++;
      if (j == 3) func = 3'b111;
    end
    start = 1'b0;
    chk("invalid busy", busy_n, 0);
    chk("invalid done", done_n, 0);
    chk("invalid err_cnt", err_cnt, tbl[4].exp_err);
    chk("invalid fail_vec", fail_vec, tbl[4].exp_fail);
    chk("invalid pass", pass, tbl[4].exp_pass);
    chk("invalid ab", {a, b}, 2'b11);

    run_check("midrun_start", 3'b010, 8'd3, 0, 7, 3'd0, 4'b0000, 1'b1);

    // Saturating one-bit counter on the second instance.
    @(negedge clk);
    start1 = 1'b1; func1 = 3'b101; hold1 = 8'd2;
    @(negedge clk);
    start1 = 1'b0;
    done_n = 0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (done1) done_n++;
    end
    chk("sat done_count", done_n, 1);
    chk("sat err_cnt", err_cnt1, 1'b1);
    chk("sat fail_vec", fail_vec1, 4'b1001);
    chk("sat pass", pass1, 1'b0);

    // Back-to-back: start held through DONE restarts one IDLE cycle later.
    cell_mode = 0;
    @(negedge clk);
    start = 1'b1; func = 3'b010; hold = 8'd1;
    done_n = 0; first_at = 0; second_at = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        if (done_n == 1) first_at = j;
        if (done_n == 2) second_at = j;
      end
    end
    start = 1'b0;
    chk("b2b done_count", done_n, 2);
    chk("b2b first_done", first_at, 5);
    chk("b2b second_done", second_at, 11);
    repeat (8) @(negedge clk);

    // Async reset during vector 2 of an H=4 run with two mismatches recorded.
    @(negedge clk);
    start = 1'b1; func = 3'b000; hold = 8'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("prereset ab", {a, b}, 2'b10);
    chk("prereset fail_vec", fail_vec, 4'b0011);
    chk("prereset err_cnt", err_cnt, 3'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst ab", {a, b}, 2'b00);
    chk("arst busy", busy, 1'b0);
    chk("arst done", done, 1'b0);
    chk("arst err_cnt", err_cnt, 3'd0);
    chk("arst fail_vec", fail_vec, 4'd0);
    chk("arst pass", pass, 1'b0);
    done_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done || busy) done_n++;
    end
    chk("post_reset idle", done_n, 0);
    run_check("post_reset_run", 3'b010, 8'd4, 0, 0, 3'd0, 4'b0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_stim_check.md
# gate_stim_check

Self-checking stimulus sequencer for 2-input gate cells. Upon start, drives inputs `a` and `b` of a gate under test through the four vectors 00, 01, 10 and 11, with a programmable hold time per vector. At the end of each hold it samples the gate output `c` and compares it against the expected truth table for the selected function. It sits directly upstream of the gate cell (it feeds the cell's `a`/`b`) and consumes the cell's `c`, replacing hand-timed stimulus.

## Interface
Parameters:
- `HOLD_W`, 8: width of the hold-time input, in clock cycles.
- `ERR_W`, 3: width of the mismatch counter, which saturates.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request a run; accepted only in IDLE.
- `func`  in  3: expected gate function. 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR; 110/111 invalid.
- `hold`  in  HOLD_W: cycles each vector is held before sampling; 0 is treated as 1.
- `a`  out  1: stimulus to gate input a, registered.
- `b`  out  1: stimulus to gate input b, registered.
- `c`  in  1: gate output under test.
- `busy`  out  1: run in progress.
- `done`  out  1: one-cycle pulse at end of run.
- `pass`  out  1: last run had zero mismatches.
- `err_cnt`  out  ERR_W: mismatches in last run, saturating.
- `fail_vec`  out  4: bit i set if vector i ({a,b}=i) mismatched.

## Operation
- States: IDLE, DRIVE, DONE.
- **IDLE:**
  - `start`=1 with valid `func` → latch `func` and `hold` (0→1).
  - Clear `err_cnt`, `fail_vec` and `pass`.
  - Set `vec`=0, {a,b}=00, `busy`=1, hold counter=1; go to DRIVE.
  - `start` with `func` 110/111 is ignored: no state change, no `done`.
- **DRIVE:**
  - Hold counter increments each cycle.
  - On the edge where counter==latched hold, sample `c` and compare against expected(func,a,b).
  - On mismatch: `err_cnt`+=1 (saturate at 2^ERR_W−1) and set `fail_vec[vec]`.
  - Then, if `vec`<3: `vec`+=1, drive the new {a,b}, reset counter to 1.
  - If `vec`==3: go to DONE, `busy`=0, `done`=1. `a`/`b` keep 11 until the next run.
- **DONE:**
  - One cycle. `pass`=(err_cnt==0) is registered on entry and holds; `done` drops; return to IDLE.
- `start` while `busy` or in DONE is ignored.
- `func`/`hold` changes mid-run have no effect; latched copies are used.
- Results (`pass`, `err_cnt`, `fail_vec`) hold until the next accepted start.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0; state IDLE.
- Asynchronous reset mid-run:
  - All outputs go to their reset values immediately.
  - No `done` pulse; partial results are discarded.
- Start accepted at edge E0:
  - Vector k is driven from edge E0+k·H to E0+(k+1)·H, where H is the latched hold.
  - `c` is sampled at edge E0+(k+1)·H. The gate therefore has H full cycles to settle.
- `done` is high during the cycle after edge E0+4H.
- Start-to-done latency is 4H+1 cycles. `busy` is high for exactly 4H cycles.
- Back-to-back runs: a `start` held high through DONE is accepted in the following IDLE cycle. Minimum run period is 4H+2 cycles.
- `c` is sampled only at the compare edge; glitches between compare edges are ignored.

## Structure
- Shared package `gate_pkg`:
  - Function-code constants (`GF_AND` … `GF_XNOR`).
  - State enum.
  - Pure function `gate_eval(func,a,b)` returning the expected output; it is reused by other gate benches.
- One natural sub-module: `hold_timer`. It holds the HOLD_W counter, with load/clear, and produces a `hit` when count==hold.
- The FSM, vector register and result registers stay in `gate_stim_check`.

## Test plan
- NAND cell attached, `func`=010, `hold`=5, start pulse → `busy` for 20 cycles, `a`/`b` = 00,01,10,11, `done` at cycle 21, `pass`=1, `err_cnt`=0, `fail_vec`=0000.
- Same NAND cell, `func`=000 (AND) → `pass`=0, `err_cnt`=4, `fail_vec`=1111.
- Cell forced to constant 1, `func`=011 (NOR), `hold`=0 → run as H=1: `busy` for 4 cycles, `done` at cycle 5, `err_cnt`=3, `fail_vec`=1110.
- `func`=110 with start → no `busy`, no `done`, outputs unchanged. `start` pulsed at cycle 7 of a valid H=3 run → ignored, single `done`.
- ERR_W=1, cell forced to 0 with `func`=101 (XNOR) → `err_cnt` saturates at 1, `fail_vec`=1001, `pass`=0.
- `rst_n` low during vector 2 of an H=4 run → `a`=`b`=0, `busy`=0, results cleared, no `done`. A new start after release runs cleanly with `pass`=1 on a correct cell.
